// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: default width, counter sizing
// and the FSM state encoding.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    // Counter must be able to hold WIDTH-1 with headroom: log2(WIDTH)+1 bits.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring radix-2 division iteration, purely combinational.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    // Shift in the next dividend bit, trial-subtract, restore on borrow.
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        // rem_in < divisor, so a successful difference always fits in WIDTH
        // bits and the low WIDTH bits of the subtraction are exact.
        trial   = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? trial : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS div/divu. One quotient bit per cycle,
// sign handling by magnitude with a final fix-up, one-cycle done pulse.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic             Sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;   // partial remainder
    logic [WIDTH-1:0] dvd_r;   // dividend magnitude, quotient bits shift in at LSB
    logic [WIDTH-1:0] dvs_r;   // divisor magnitude
    logic             neg_q;
    logic             neg_r;
    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    // A new request is only taken outside CALC, and never alongside a flush.
    assign accept    = start && !flush && (state != CALC);
    assign last_step = (state == CALC) && (cnt == LAST_STEP);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[WIDTH-1]),
        .divisor (dvs_r),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Final quotient/remainder after the last step, with signs restored.
    always_comb begin
        q_raw = {dvd_r[WIDTH-2:0], step_q};
        q_fix = neg_q ? -q_raw : q_raw;
        r_fix = neg_r ? -step_rem : step_rem;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; flush overrides everything except reset.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
                else        state_nxt = IDLE;
            end
            CALC: begin
                if (cnt == LAST_STEP) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            rem_r       <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            rem_r <= '0;
            dvd_r <= magnitude(dividend, Sign);
            dvs_r <= magnitude(divisor, Sign);
            neg_q <= Sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= Sign && dividend[WIDTH-1];
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC && !flush) begin
            cnt   <= cnt + CNT_W'(1);
            rem_r <= step_rem;
            dvd_r <= q_raw;
            if (last_step) begin
                quotient    <= q_fix;
                remainder   <= r_fix;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a cycle-timed arithmetic model is compared
// against the DUT on every cycle, plus hand-computed expectations per vector.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = DIV_WIDTH;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic         Sign;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .flush       (flush),
        .Sign        (Sign),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: 64-bit signed division truncates toward zero and
    // gives the remainder the dividend's sign, which is exactly MIPS div.
    function automatic res_t model_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   res;
        longint sa;
        longint sb;
        if (b == '0) begin
            res.q  = '1;
            res.r  = a;
            res.dz = 1'b1;
            return res;
        end
        sa     = s ? longint'($signed(a)) : longint'(a);
        sb     = s ? longint'($signed(b)) : longint'(b);
        res.q  = W'(sa / sb);
        res.r  = W'(sa % sb);
        res.dz = 1'b0;
        return res;
    endfunction

    // Model: cycle count, the pending result and the cycle it becomes visible.
    longint m_cyc   = 0;
    longint m_due   = 0;
    bit     m_have  = 1'b0;
    bit     m_zero  = 1'b0;
    bit     m_valid = 1'b0;
    res_t   m_pend  = '0;
    res_t   m_held  = '0;

    always @(posedge clk) begin : model
        bit was_busy;
        was_busy = m_have && !m_zero && (m_cyc < m_due);
        m_cyc++;
        if (reset) begin
            m_have  = 1'b0;
            m_held  = '0;
            m_valid = 1'b1;
        end else if (flush) begin
            m_have = 1'b0;
        end else if (start && !was_busy) begin
            m_pend = model_div(Sign, dividend, divisor);
            m_zero = (divisor == '0);
            m_due  = m_cyc + (m_zero ? 0 : W);
            m_have = 1'b1;
        end
        if (m_have && m_cyc == m_due) m_held = m_pend;
    end

    always @(negedge clk) begin : compare
        if (m_valid) begin
            check("busy",        busy,        m_have && !m_zero && (m_cyc < m_due));
            check("done",        done,        m_have && (m_cyc == m_due));
            check("quotient",    quotient,    m_held.q);
            check("remainder",   remainder,   m_held.r);
            check("div_by_zero", div_by_zero, m_held.dz);
        end
    end

    // Issue one division and wait (bounded) for done; pin latency and results.
    task automatic div_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int lat      = 0;
        int busy_cnt = 0;
        Sign     = s;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({tag, " latency"},     lat,         exp_lat);
        check({tag, " busy cycles"}, busy_cnt,    exp_lat - 1);
        check({tag, " quotient"},    quotient,    eq);
        check({tag, " remainder"},   remainder,   er);
        check({tag, " div_by_zero"}, div_by_zero, edz);
    endtask

    initial begin : stim
        int lat;
        reset    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        Sign     = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset busy",        busy,        0);
        check("reset done",        done,        0);
        check("reset quotient",    quotient,    0);
        check("reset remainder",   remainder,   0);
        check("reset div_by_zero", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        div_op("u 100/7",  1'b0, 32'd100,        32'd7,          33, 32'd14,         32'd2,          1'b0);
        div_op("s -7/2",   1'b1, 32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        div_op("s 7/-2",   1'b1, 32'd7,          32'hFFFF_FFFE,  33, 32'hFFFF_FFFD,  32'd1,          1'b0);
        div_op("s -100/-7",1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  33, 32'd14,         32'hFFFF_FFFE,  1'b0);
        div_op("u 5/0",    1'b0, 32'd5,          32'd0,          1,  32'hFFFF_FFFF,  32'd5,          1'b1);
        div_op("s -7/0",   1'b1, 32'hFFFF_FFF9,  32'd0,          1,  32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1);
        repeat (2) @(negedge clk);
        div_op("s ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'h8000_0000,  32'd0,          1'b0);
        div_op("u ovf",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'd0,          32'h8000_0000,  1'b0);
        div_op("u max/16", 1'b0, 32'hFFFF_FFFF,  32'd16,         33, 32'h0FFF_FFFF,  32'hF,          1'b0);

        // Flush on the 10th CALC cycle: work dropped, outputs keep 14/2 result.
        div_op("u 14/2",   1'b0, 32'd14,         32'd2,          33, 32'd7,          32'd0,          1'b0);
        repeat (2) @(negedge clk);
        Sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy",      busy,      0);
        check("flush done",      done,      0);
        check("flush quotient",  quotient,  32'd7);
        check("flush remainder", remainder, 32'd0);
        repeat (3) @(negedge clk);
        div_op("u 9/4 after flush", 1'b0, 32'd9, 32'd4, 33, 32'd2, 32'd1, 1'b0);

        // start pulsed mid-CALC with different operands must be ignored.
        repeat (2) @(negedge clk);
        lat = 0;
        Sign = 1'b0; dividend = 32'd50; divisor = 32'd6; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = (i == 5);
            if (i == 5) begin
                dividend = 32'd1;
                divisor  = 32'd1;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check("ignored start latency",   lat,       33);
        check("ignored start quotient",  quotient,  32'd8);
        check("ignored start remainder", remainder, 32'd2);

        // Back-to-back: second start issued in the DONE cycle of the first.
        @(negedge clk);
        div_op("u 20/3",   1'b0, 32'd20, 32'd3, 33, 32'd6, 32'd2, 1'b0);
        div_op("u 9/4 b2b",1'b0, 32'd9,  32'd4, 33, 32'd2, 32'd1, 1'b0);

        // Reset in the middle of CALC clears everything on the next cycle.
        repeat (2) @(negedge clk);
        Sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset busy",        busy,        0);
        check("mid reset done",        done,        0);
        check("mid reset quotient",    quotient,    0);
        check("mid reset remainder",   remainder,   0);
        check("mid reset div_by_zero", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);
        div_op("u 1000/3", 1'b0, 32'd1000, 32'd3, 33, 32'd333, 32'd1, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative integer divider for the pipelined CPU. It is the inverse-direction companion to the single-cycle ALU multiply path and services MIPS div/divu.
- Accepts a dividend/divisor pair with a start pulse and runs a restoring radix-2 division, one quotient bit per cycle.
- Returns quotient and remainder, intended for HI/LO, with a one-cycle done pulse.
- The pipeline stalls on busy.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- flush  input  1  abort any in-flight division (pipeline flush).
- Sign  input  1  1 = signed (div), 0 = unsigned (divu); captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- busy  output  1  high while iterating (state CALC).
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  registered quotient (LO).
- remainder  output  WIDTH  registered remainder (HI).
- div_by_zero  output  1  registered; set with done when divisor was 0.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and registers are cleared.
  - Reset mid-operation aborts immediately with the same values.
- States: IDLE, CALC, DONE.
- IDLE or DONE with start=1 and flush=0:
  - Capture operands and Sign.
  - If divisor==0, go to DONE.
  - Otherwise go to CALC with counter=0.
  - A start accepted in DONE still shows done=1 for that cycle, so back-to-back operation is legal.
- CALC: start is ignored. Each cycle runs one restoring step:
  - Shift {partial remainder, dividend magnitude} left 1.
  - Trial-subtract the divisor magnitude (WIDTH+1-bit compare).
  - Set the quotient LSB on non-negative result and keep the difference; otherwise restore.
  - counter increments; after WIDTH steps (counter==WIDTH-1 processed), go to DONE.
- DONE:
  - done=1 for exactly one cycle. quotient, remainder and div_by_zero are loaded on entry.
  - Next state is IDLE, or CALC/DONE if a new start is accepted.
- Latency:
  - Start accepted at edge E0 gives done high in the cycle after edge E0+WIDTH, i.e. 33 cycles for WIDTH=32.
  - Divide-by-zero gives done in the cycle after E0 (1 cycle).
- Output hold: quotient, remainder and div_by_zero hold their last values until the next DONE entry. They do not change during CALC.
- Signed mode:
  - Operate on magnitudes.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - Truncation toward zero, per the MIPS convention.
- Overflow case, Sign=1 with 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. This is the natural wrap; no flag.
- Divide by zero: quotient=all ones, remainder=dividend (unmodified), div_by_zero=1.
- Flush:
  - In any state, flush=1 forces IDLE next cycle and drops any in-progress work.
  - No done is produced; outputs keep their prior values.
  - flush has priority over start in the same cycle.
- Simultaneous reset and flush: reset wins and outputs clear.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - DIV_WIDTH=32.
  - Counter width, log2(WIDTH)+1.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, current dividend bit, divisor magnitude.
  - Outputs: next remainder and quotient bit.
- FSM, counter, sign fix-up and output registers live in div_unit.

Test Plan:
- Unsigned 100/7: start with Sign=0 → busy for 32 cycles, done on cycle 33, quotient=14, remainder=2, div_by_zero=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002, Sign=1) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also 7/-2 → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero, 5/0 → done one cycle after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, busy never asserted.
- Overflow 0x80000000 / 0xFFFFFFFF:
  - Sign=1 → quotient=0x80000000, remainder=0.
  - Sign=0 → quotient=0, remainder=0x80000000.
- Flush at cycle 10 of CALC → busy=0 next cycle, no done pulse, outputs still hold the previous result (e.g. 14/2). A fresh start then completes normally.
- Start pulsed during CALC is ignored, and the original result is produced. Start in the DONE cycle (20/3, then 9/4) → second done 33 cycles later with quotient=2, remainder=1. Reset asserted mid-CALC → all outputs 0 on the next cycle.
